// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Round-robin arbiter that merges several register-file write requesters
// (0=ALU, 1=LSU, 2=debug) onto the single write port WE3/AD3/WD3.
// A handshake (req_valid & req_ready) in cycle N drives the write port in
// cycle N+1. Writes to address 0 are acknowledged but suppressed and counted
// in a saturating drop counter.
// Optional feature: define RF_WB_FWD_EN to add two write-back forwarding
// compare ports (fwd_addr1/2 -> fwd_hit1/2, fwd_data1/2).

module regfile_wb_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NREQ          = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          stall,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ*ADDRESS_WIDTH-1:0] req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]               req_ready,
    output logic                          WE3,
    output logic [ADDRESS_WIDTH-1:0]      AD3,
    output logic [DATA_WIDTH-1:0]         WD3,
    output logic [1:0]                    grant_id,
`ifdef RF_WB_FWD_EN
    input  logic [ADDRESS_WIDTH-1:0]      fwd_addr1,
    input  logic [ADDRESS_WIDTH-1:0]      fwd_addr2,
    output logic                          fwd_hit1,
    output logic                          fwd_hit2,
    output logic [DATA_WIDTH-1:0]         fwd_data1,
    output logic [DATA_WIDTH-1:0]         fwd_data2,
`endif
    output logic [7:0]                    drop_cnt
);

    // Pointer width; at least one bit so a single-requester build still elaborates.
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Round-robin pick: first valid requester scanning upward from ptr, wrapping.
    function automatic logic [NREQ-1:0] f_rr_pick(
        input logic [NREQ-1:0] valid,
        input logic [PW-1:0]   ptr
    );
        logic [NREQ-1:0] pick;
        logic            found;
        int              idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && valid[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // One-hot to binary index; a zero vector encodes to index 0.
    function automatic logic [PW-1:0] f_onehot_idx(input logic [NREQ-1:0] onehot);
        logic [PW-1:0] idx;
        idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (onehot[k]) begin
                idx = PW'(k);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [PW-1:0]            r_ptr;
    logic                     r_we3;
    logic [ADDRESS_WIDTH-1:0] r_ad3;
    logic [DATA_WIDTH-1:0]    r_wd3;
    logic [1:0]               r_grant_id;
    logic [7:0]               r_drop_cnt;

    logic [NREQ-1:0]          w_ready;
    logic                     w_grant;
    logic [PW-1:0]            w_gidx;
    logic [ADDRESS_WIDTH-1:0] w_gaddr;
    logic [DATA_WIDTH-1:0]    w_gdata;
    logic                     w_addr_zero;
    logic [PW-1:0]            w_ptr_next;

    // Grant selection, granted payload mux and next round-robin pointer.
    always_comb begin
        w_ready     = '0;
        w_grant     = 1'b0;
        w_gidx      = '0;
        w_gaddr     = '0;
        w_gdata     = '0;
        w_addr_zero = 1'b0;
        w_ptr_next  = r_ptr;
        // No grants while frozen or while reset is held.
        if (rst_n && !stall) begin
            w_ready = f_rr_pick(req_valid, r_ptr);
        end else begin
            w_ready = '0;
        end
        w_grant     = |w_ready;
        w_gidx      = f_onehot_idx(w_ready);
        w_gaddr     = req_addr[int'(w_gidx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        w_gdata     = req_data[int'(w_gidx)*DATA_WIDTH +: DATA_WIDTH];
        w_addr_zero = (w_gaddr == '0);
        if (w_grant) begin
            if (w_gidx == PW'(NREQ - 1)) begin
                w_ptr_next = '0;
            end else begin
                w_ptr_next = w_gidx + PW'(1);
            end
        end else begin
            w_ptr_next = r_ptr;
        end
    end

    assign req_ready = w_ready;

    // Round-robin pointer: advances past the granted requester, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end

    // Write-port register: one-cycle latency, address-0 writes suppressed,
    // address/data/id hold when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we3      <= 1'b0;
            r_ad3      <= '0;
            r_wd3      <= '0;
            r_grant_id <= 2'd0;
        end else begin
            r_we3 <= w_grant & ~w_addr_zero;
            if (w_grant) begin
                r_ad3      <= w_gaddr;
                r_wd3      <= w_gdata;
                r_grant_id <= 2'(w_gidx);
            end
        end
    end

    // Saturating count of acknowledged-but-suppressed address-0 writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= 8'd0;
        end else if (w_grant && w_addr_zero && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign WE3      = r_we3;
    assign AD3      = r_ad3;
    assign WD3      = r_wd3;
    assign grant_id = r_grant_id;
    assign drop_cnt = r_drop_cnt;

`ifdef RF_WB_FWD_EN
    // Forwarding compare against the write currently on the port; address 0 never hits.
    always_comb begin
        fwd_hit1  = r_we3 && (r_ad3 == fwd_addr1) && (fwd_addr1 != '0);
        fwd_hit2  = r_we3 && (r_ad3 == fwd_addr2) && (fwd_addr2 != '0);
        if (fwd_hit1) begin
            fwd_data1 = r_wd3;
        end else begin
            fwd_data1 = '0;
        end
        if (fwd_hit2) begin
            fwd_data2 = r_wd3;
        end else begin
            fwd_data2 = '0;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus pushes expected writes,
// a monitor pops and compares each cycle WE3 is high.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [2:0]  req_valid;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        WE3;
    logic [4:0]  AD3;
    logic [31:0] WD3;
    logic [1:0]  grant_id;
    logic [7:0]  drop_cnt;
`ifdef RF_WB_FWD_EN
    logic [4:0]  fwd_addr1;
    logic [4:0]  fwd_addr2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;
`endif

    regfile_wb_arbiter #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .NREQ(3)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .WE3(WE3), .AD3(AD3), .WD3(WD3),
        .grant_id(grant_id),
`ifdef RF_WB_FWD_EN
        .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
`endif
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ad;
        logic [31:0] wd;
        logic [1:0]  gid;
    } wr_t;

    wr_t q[$];
    int  n_checks = 0;
    int  n_bad    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of requests at the falling edge, check the grant,
    // and queue the write the port should show one cycle later.
    task automatic step(input logic [2:0] v,
                        input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                        input logic s, input logic [2:0] er, input string nm);
        logic [4:0]  aa[3];
        logic [31:0] dd[3];
        wr_t         e;
        aa = '{a0, a1, a2};
        dd = '{d0, d1, d2};
        @(negedge clk);
        req_valid = v;
        req_addr  = {a2, a1, a0};
        req_data  = {d2, d1, d0};
        stall     = s;
        #1;
        chk(nm, 64'(req_ready), 64'(er));
        for (int i = 0; i < 3; i++) begin
            if (er[i] && aa[i] != 5'd0) begin
                e.ad  = aa[i];
                e.wd  = dd[i];
                e.gid = 2'(i);
                q.push_back(e);
            end
        end
    endtask

    task automatic idle(input string nm);
        step(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'b000, nm);
    endtask

    // Monitor: every write presented on the port must match the next queued one.
    always @(posedge clk) begin
        wr_t e;
        #1;
        if (WE3 === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_bad++;
                $display("FAIL wb_spurious: WE3=1 AD3=%0d WD3=0x%0h with nothing expected", AD3, WD3);
            end else begin
                e = q.pop_front();
                chk("wb_ad3", 64'(AD3), 64'(e.ad));
                chk("wb_wd3", 64'(WD3), 64'(e.wd));
                chk("wb_gid", 64'(grant_id), 64'(e.gid));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b1;
        stall     = 1'b0;
        req_valid = 3'b111;
        req_addr  = {5'd3, 5'd2, 5'd1};
        req_data  = 96'd0;
`ifdef RF_WB_FWD_EN
        fwd_addr1 = 5'd0;
        fwd_addr2 = 5'd0;
`endif
        #1 rst_n = 1'b0;
        #2;
        // Reset state, and no grants while reset is held
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_we3", 64'(WE3), 64'd0);
        chk("rst_ad3", 64'(AD3), 64'd0);
        chk("rst_wd3", 64'(WD3), 64'd0);
        chk("rst_gid", 64'(grant_id), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        req_valid = 3'b000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write from requester 0
        step(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'd0, 32'd0, 1'b0, 3'b001, "single_ready");
        idle("idle_a");
        idle("idle_b");
        chk("hold_we3", 64'(WE3), 64'd0);
        chk("hold_ad3", 64'(AD3), 64'd5);
        chk("hold_wd3", 64'(WD3), 64'hDEADBEEF);
        chk("hold_gid", 64'(grant_id), 64'd0);

        // Pointer is 1; grant 2 brings it back to 0
        step(3'b100, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'h0000_0C0C, 1'b0, 3'b100, "realign");
        // All three valid for 6 cycles: 0,1,2,0,1,2 back-to-back
        for (int i = 0; i < 6; i++) begin
            step(3'b111, 5'd10, 5'd11, 5'd12, 32'hA0, 32'hA1, 32'hA2, 1'b0,
                 3'(1 << (i % 3)), "rr_ready");
        end
        idle("idle_c");

        // Requester 1 writes address 0 three times: acknowledged, dropped
        for (int i = 0; i < 3; i++) begin
            step(3'b010, 5'd0, 5'd0, 5'd0, 32'd0, 32'h1111, 32'd0, 1'b0, 3'b010, "zero_ready");
        end
        idle("idle_d");
        chk("drop_3", 64'(drop_cnt), 64'd3);

        // Stall two cycles with 0,1 valid; pointer is 2 so first grant is 0
        step(3'b011, 5'd3, 5'd4, 5'd0, 32'h33, 32'h44, 32'd0, 1'b1, 3'b000, "stall_ready1");
        step(3'b011, 5'd3, 5'd4, 5'd0, 32'h33, 32'h44, 32'd0, 1'b1, 3'b000, "stall_ready2");
        chk("stall_we3", 64'(WE3), 64'd0);
        step(3'b011, 5'd3, 5'd4, 5'd0, 32'h33, 32'h44, 32'd0, 1'b0, 3'b001, "post_stall0");
        step(3'b011, 5'd3, 5'd4, 5'd0, 32'h33, 32'h44, 32'd0, 1'b0, 3'b010, "post_stall1");
        idle("idle_e");

        // Async reset while WE3 is high
        step(3'b001, 5'd6, 5'd0, 5'd0, 32'h55, 32'd0, 32'd0, 1'b0, 3'b001, "pre_rst_ready");
        @(posedge clk);
        #3;
        chk("pre_rst_we3", 64'(WE3), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_we3", 64'(WE3), 64'd0);
        chk("arst_ad3", 64'(AD3), 64'd0);
        chk("arst_wd3", 64'(WD3), 64'd0);
        chk("arst_drop", 64'(drop_cnt), 64'd0);
        chk("arst_ready", 64'(req_ready), 64'd0);
        req_valid = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        step(3'b111, 5'd17, 5'd18, 5'd19, 32'h71, 32'h72, 32'h73, 1'b0, 3'b001, "after_rst");
        idle("idle_f");

        // Drop counter saturation (pointer is 1)
        for (int i = 0; i < 256; i++) begin
            step(3'b010, 5'd0, 5'd0, 5'd0, 32'd0, 32'h2222, 32'd0, 1'b0, 3'b010, "sat_ready");
        end
        idle("idle_g");
        chk("drop_sat", 64'(drop_cnt), 64'd255);

`ifdef RF_WB_FWD_EN
        // Forwarding hit on the write currently on the port (pointer is 2)
        fwd_addr1 = 5'd7;
        fwd_addr2 = 5'd0;
        step(3'b001, 5'd7, 5'd0, 5'd0, 32'h12345678, 32'd0, 32'd0, 1'b0, 3'b001, "fwd_ready");
        @(posedge clk);
        #2;
        chk("fwd_hit1", 64'(fwd_hit1), 64'd1);
        chk("fwd_data1", 64'(fwd_data1), 64'h12345678);
        chk("fwd_hit2", 64'(fwd_hit2), 64'd0);
        chk("fwd_data2", 64'(fwd_data2), 64'd0);
        idle("idle_h");
`endif

        idle("idle_z");
        idle("idle_z");
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
